host_cmd_receiver: RTL and testbench

//  Host->FPGA command path. Pulls bytes from the Sync_245_Controller receive side (hostData/hasData/readData),

---
 rtl/host_cmd_pkg.sv | 32 +++
 rtl/host_cmd_if.sv | 15 +
 rtl/host_byte_fetch.sv | 39 +++
 rtl/host_cmd_receiver.sv | 154 +++++++++++++++
 tb/tb_host_cmd_receiver.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/host_cmd_pkg.sv
// Shared definitions for the host command receiver: opcodes, sync byte, FSM states.
// The ACK_WAIT state exists only when HOST_CMD_ACK_EN is defined.
package host_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;

  localparam logic [7:0] OPC_START    = 8'h01;
  localparam logic [7:0] OPC_STOP     = 8'h02;
  localparam logic [7:0] OPC_SCCB_WR  = 8'h03;
  localparam logic [7:0] OPC_SOFT_RST = 8'h04;

  localparam int ACK_STATUS_BIT = 7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_OPC,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_GET_CHK,
    ST_EXEC,
    ST_SCCB_WAIT,
    ST_RST_HOLD
`ifdef HOST_CMD_ACK_EN
    , ST_ACK_WAIT
`endif
  } state_e;

  function automatic logic opc_valid(input logic [7:0] opc);
    return (opc >= OPC_START) && (opc <= OPC_SOFT_RST);
  endfunction

endpackage

// File: rtl/host_cmd_if.sv
// Byte-receive handshake from the FTDI controller plus the SCCB write request channel.
interface host_cmd_if;
  logic [7:0] host_data;
  logic       has_data;
  logic       read_data;
  logic       sccb_req;
  logic [7:0] sccb_addr;
  logic [7:0] sccb_wdata;
  logic       sccb_ack;

  modport master (output host_data, has_data, sccb_ack,
                  input  read_data, sccb_req, sccb_addr, sccb_wdata);
  modport slave  (input  host_data, has_data, sccb_ack,
                  output read_data, sccb_req, sccb_addr, sccb_wdata);
endinterface

// File: rtl/host_byte_fetch.sv
// Pop strobe generation, sample-cycle flag and inter-byte timeout counter.
// rx_byte is valid in the cycle byte_vld is high (one cycle after read_data).
module host_byte_fetch #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch_en,
  input  logic       count_en,
  input  logic [7:0] host_data,
  input  logic       has_data,
  output logic       read_data,
  output logic       byte_vld,
  output logic [7:0] rx_byte,
  output logic       timeout
);
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic          pending;
  logic [TW-1:0] cnt;

  // pending blocks a second pop while the previous byte is still in flight
  assign read_data = fetch_en & has_data & ~pending & ~reset;
  assign byte_vld  = pending;
  assign rx_byte   = host_data;
  assign timeout   = count_en & (cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      cnt     <= '0;
    end else begin
      pending <= read_data;
      if (!count_en || pending || timeout) cnt <= '0;
      else                                 cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/host_cmd_receiver.sv
// Frames [SYNC][OPC][ADDR][DATA][CHK] host packets and executes stream/SCCB/soft-reset commands.
// Define HOST_CMD_ACK_EN to add the ack_data/ack_valid/ack_ready response channel.
module host_cmd_receiver
  import host_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 1024,
  parameter int         RST_CYC     = 4
) (
  input  logic        sys_clk,
  input  logic        reset,
  host_cmd_if.slave   bus,
  output logic        stream_en,
  output logic        soft_rst,
  output logic        cmd_err,
  output logic [15:0] pkt_count
`ifdef HOST_CMD_ACK_EN
  , output logic [7:0] ack_data
  , output logic       ack_valid
  , input  logic       ack_ready
`endif
);
  localparam int RC_W = $clog2(RST_CYC + 1);

  state_e          state, state_d, done_st;
  logic            fetch_en, count_en, byte_vld, timeout;
  logic [7:0]      rx_byte;
  logic [7:0]      opc_q, addr_q, data_q;
  logic            exec_ok, pkt_good, pkt_bad;
  logic [RC_W-1:0] rst_cnt;
  logic            sccb_req;
  logic [7:0]      sccb_addr, sccb_wdata;

  host_byte_fetch #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_fetch (
    .clk      (sys_clk),
    .reset    (reset),
    .fetch_en (fetch_en),
    .count_en (count_en),
    .host_data(bus.host_data),
    .has_data (bus.has_data),
    .read_data(bus.read_data),
    .byte_vld (byte_vld),
    .rx_byte  (rx_byte),
    .timeout  (timeout)
  );

  assign bus.sccb_req   = sccb_req;
  assign bus.sccb_addr  = sccb_addr;
  assign bus.sccb_wdata = sccb_wdata;

  always_comb begin
`ifdef HOST_CMD_ACK_EN
    done_st = ST_ACK_WAIT;
`else
    done_st = ST_IDLE;
`endif
    count_en = state inside {ST_GET_OPC, ST_GET_ADDR, ST_GET_DATA, ST_GET_CHK};
    fetch_en = count_en | (state == ST_IDLE);
    // checksum/opcode verdict is taken as CHK lands so effects show one cycle later
    pkt_good = 1'b0;
    pkt_bad  = 1'b0;
    if (state == ST_GET_CHK && byte_vld && !timeout) begin
      if (rx_byte == (opc_q ^ addr_q ^ data_q) && opc_valid(opc_q)) pkt_good = 1'b1;
      else                                                         pkt_bad  = 1'b1;
    end
    state_d = state;
    case (state)
      ST_IDLE:      if (byte_vld && rx_byte == SYNC_BYTE) state_d = ST_GET_OPC;
      ST_GET_OPC:   if (timeout) state_d = ST_IDLE; else if (byte_vld) state_d = ST_GET_ADDR;
      ST_GET_ADDR:  if (timeout) state_d = ST_IDLE; else if (byte_vld) state_d = ST_GET_DATA;
      ST_GET_DATA:  if (timeout) state_d = ST_IDLE; else if (byte_vld) state_d = ST_GET_CHK;
      ST_GET_CHK:   if (timeout) state_d = ST_IDLE; else if (byte_vld) state_d = ST_EXEC;
      ST_EXEC: begin
        if (!exec_ok)                    state_d = done_st;
        else if (opc_q == OPC_SCCB_WR)   state_d = ST_SCCB_WAIT;
        else if (opc_q == OPC_SOFT_RST)  state_d = ST_RST_HOLD;
        else                             state_d = done_st;
      end
      ST_SCCB_WAIT: if (bus.sccb_ack)      state_d = done_st;
      ST_RST_HOLD:  if (rst_cnt == '0)     state_d = done_st;
`ifdef HOST_CMD_ACK_EN
      ST_ACK_WAIT:  if (ack_ready)         state_d = ST_IDLE;
`endif
      default:                             state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      opc_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      exec_ok    <= 1'b0;
      stream_en  <= 1'b0;
      soft_rst   <= 1'b0;
      rst_cnt    <= '0;
      sccb_req   <= 1'b0;
      sccb_addr  <= '0;
      sccb_wdata <= '0;
      cmd_err    <= 1'b0;
      pkt_count  <= '0;
`ifdef HOST_CMD_ACK_EN
      ack_data   <= '0;
      ack_valid  <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      cmd_err <= pkt_bad | timeout;
      if (byte_vld) begin
        case (state)
          ST_GET_OPC:  opc_q  <= rx_byte;
          ST_GET_ADDR: addr_q <= rx_byte;
          ST_GET_DATA: data_q <= rx_byte;
          default: ;
        endcase
      end
      if (pkt_bad) exec_ok <= 1'b0;
      if (pkt_good) begin
        exec_ok   <= 1'b1;
        pkt_count <= pkt_count + 16'd1;
        case (opc_q)
          OPC_START: stream_en <= 1'b1;
          OPC_STOP:  stream_en <= 1'b0;
          OPC_SCCB_WR: begin
            sccb_req   <= 1'b1;
            sccb_addr  <= addr_q;
            sccb_wdata <= data_q;
          end
          OPC_SOFT_RST: begin
            soft_rst  <= 1'b1;
            rst_cnt   <= RC_W'(RST_CYC - 1);
            stream_en <= 1'b0;
          end
          default: ;
        endcase
      end else if (rst_cnt != '0) begin
        rst_cnt <= rst_cnt - RC_W'(1);
      end else begin
        soft_rst <= 1'b0;
      end
      if (state == ST_SCCB_WAIT && bus.sccb_ack) sccb_req <= 1'b0;
`ifdef HOST_CMD_ACK_EN
      if (state_d == ST_ACK_WAIT && state != ST_ACK_WAIT) begin
        ack_valid <= 1'b1;
        ack_data  <= {exec_ok, opc_q[6:0]};
      end else if (ack_valid && ack_ready) begin
        ack_valid <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_host_cmd_receiver.sv
// Directed bench for host_cmd_receiver; a task-level FTDI model feeds one byte per pop.
// Builds with or without HOST_CMD_ACK_EN.
`timescale 1ns/1ps
module tb_host_cmd_receiver;
  import host_cmd_pkg::*;

  logic        sys_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        stream_en, soft_rst, cmd_err;
  logic [15:0] pkt_count;
`ifdef HOST_CMD_ACK_EN
  logic [7:0]  ack_data;
  logic        ack_valid;
  logic        ack_ready = 1'b1;
`endif
  int n_cmp = 0, n_bad = 0, err_pulses = 0;

  host_cmd_if bus();

  host_cmd_receiver #(.SYNC_BYTE(8'hAA), .TIMEOUT_CYC(1024), .RST_CYC(4)) dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .bus      (bus.slave),
    .stream_en(stream_en),
    .soft_rst (soft_rst),
    .cmd_err  (cmd_err),
    .pkt_count(pkt_count)
`ifdef HOST_CMD_ACK_EN
    , .ack_data (ack_data)
    , .ack_valid(ack_valid)
    , .ack_ready(ack_ready)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (cmd_err === 1'b1) err_pulses++;
    n_cmp++;
    if (bus.read_data === 1'b1 && bus.has_data !== 1'b1) begin
      n_bad++;
      $display("FAIL pop_without_data: read_data=1 has_data=%b at %0t", bus.has_data, $time);
    end
  end

  // Offer one byte; it is presented the cycle after the pop and the task returns in that cycle.
  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    bus.has_data = 1'b1;
    @(negedge sys_clk);
    while (bus.read_data !== 1'b1 && w < 50) begin
      @(negedge sys_clk);
      w++;
    end
    if (bus.read_data !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL pop_wait: no read_data within 50 cycles for byte %h", b);
    end
    @(posedge sys_clk); #1;
    bus.host_data = b;
    bus.has_data  = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] a, o, ad, d, c);
    send_byte(a); send_byte(o); send_byte(ad); send_byte(d); send_byte(c);
  endtask

  task automatic step();
    @(posedge sys_clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.has_data = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    n_cmp++; if (bus.read_data !== 1'b0) begin n_bad++; $display("FAIL reset_read_data: got %b want 0", bus.read_data); end
    n_cmp++; if ({stream_en, soft_rst, cmd_err, bus.sccb_req} !== 4'b0000) begin n_bad++;
      $display("FAIL reset_outputs: got %b want 0000", {stream_en, soft_rst, cmd_err, bus.sccb_req}); end
    n_cmp++; if (pkt_count !== 16'd0) begin n_bad++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
`ifdef HOST_CMD_ACK_EN
    n_cmp++; if (ack_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ack_valid: got %b want 0", ack_valid); end
`endif
    bus.has_data = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_start();
    int e0 = err_pulses;
    send_pkt(8'hAA, 8'h01, 8'h00, 8'h00, 8'h01);
    n_cmp++; if (stream_en !== 1'b0) begin n_bad++; $display("FAIL start_early: stream_en got %b want 0 on CHK cycle", stream_en); end
    step();
    n_cmp++; if (stream_en !== 1'b1) begin n_bad++; $display("FAIL start_stream_en: got %b want 1", stream_en); end
    n_cmp++; if (pkt_count !== 16'd1) begin n_bad++; $display("FAIL start_pkt_count: got %0d want 1", pkt_count); end
    repeat (3) step();
    n_cmp++; if (err_pulses != e0) begin n_bad++; $display("FAIL start_no_err: got %0d pulses want 0", err_pulses - e0); end
  endtask

  task automatic test_sccb();
    send_pkt(8'hAA, 8'h03, 8'h12, 8'h80, 8'h91);
    step();
    n_cmp++; if ({bus.sccb_req, bus.sccb_addr, bus.sccb_wdata} !== {1'b1, 8'h12, 8'h80}) begin n_bad++;
      $display("FAIL sccb_req: got req=%b addr=%h wdata=%h want 1/12/80", bus.sccb_req, bus.sccb_addr, bus.sccb_wdata); end
    bus.has_data = 1'b1;
    repeat (4) begin
      step();
      n_cmp++; if (bus.read_data !== 1'b0) begin n_bad++; $display("FAIL sccb_no_pop: read_data got %b want 0", bus.read_data); end
    end
    n_cmp++; if (bus.sccb_req !== 1'b1) begin n_bad++; $display("FAIL sccb_hold: req got %b want 1", bus.sccb_req); end
    bus.has_data = 1'b0;
    bus.sccb_ack = 1'b1;
    step();
    bus.sccb_ack = 1'b0;
    n_cmp++; if (bus.sccb_req !== 1'b0) begin n_bad++; $display("FAIL sccb_drop: req got %b want 0", bus.sccb_req); end
    n_cmp++; if (pkt_count !== 16'd2) begin n_bad++; $display("FAIL sccb_pkt_count: got %0d want 2", pkt_count); end
  endtask

  task automatic test_bad_chk();
    send_pkt(8'hAA, 8'h01, 8'h00, 8'h00, 8'h00);
    step();
    n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL badchk_err: got %b want 1", cmd_err); end
    n_cmp++; if ({stream_en, pkt_count} !== {1'b1, 16'd2}) begin n_bad++;
      $display("FAIL badchk_state: stream_en=%b pkt_count=%0d want 1/2", stream_en, pkt_count); end
    step();
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL badchk_pulse: got %b want 0", cmd_err); end
  endtask

  task automatic test_resync();
    int e0 = err_pulses;
    send_byte(8'h55); send_byte(8'h33);
    send_pkt(8'hAA, 8'h02, 8'h00, 8'h00, 8'h02);
    step();
    n_cmp++; if ({stream_en, pkt_count} !== {1'b0, 16'd3}) begin n_bad++;
      $display("FAIL resync_stop: stream_en=%b pkt_count=%0d want 0/3", stream_en, pkt_count); end
    step();
    n_cmp++; if (err_pulses != e0) begin n_bad++; $display("FAIL resync_no_err: got %0d pulses want 0", err_pulses - e0); end
  endtask

  task automatic test_timeout();
    int k = 0;
    send_byte(8'hAA); send_byte(8'h01);
    while (k < 1200) begin
      step();
      k++;
      if (cmd_err === 1'b1) break;
    end
    n_cmp++; if (cmd_err !== 1'b1 || k < 1024 || k > 1026) begin n_bad++;
      $display("FAIL timeout_err: cmd_err=%b after %0d cycles want 1 after 1024..1026", cmd_err, k); end
    step();
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL timeout_pulse: got %b want 0", cmd_err); end
    send_pkt(8'hAA, 8'h01, 8'h00, 8'h00, 8'h01);
    step();
    n_cmp++; if ({stream_en, pkt_count} !== {1'b1, 16'd4}) begin n_bad++;
      $display("FAIL timeout_recover: stream_en=%b pkt_count=%0d want 1/4", stream_en, pkt_count); end
  endtask

  task automatic test_soft_rst();
    int hi = 0;
`ifdef HOST_CMD_ACK_EN
    int w = 0;
    ack_ready = 1'b0;
`endif
    send_pkt(8'hAA, 8'h04, 8'h00, 8'h00, 8'h04);
    step();
    n_cmp++; if ({soft_rst, stream_en} !== 2'b10) begin n_bad++;
      $display("FAIL softrst_start: soft_rst=%b stream_en=%b want 1/0", soft_rst, stream_en); end
    while (soft_rst === 1'b1 && hi < 20) begin hi++; step(); end
    n_cmp++; if (hi != 4) begin n_bad++; $display("FAIL softrst_width: got %0d cycles want 4", hi); end
    n_cmp++; if (pkt_count !== 16'd5) begin n_bad++; $display("FAIL softrst_pkt_count: got %0d want 5", pkt_count); end
`ifdef HOST_CMD_ACK_EN
    while (ack_valid !== 1'b1 && w < 10) begin w++; step(); end
    repeat (3) step();
    n_cmp++; if ({ack_valid, ack_data} !== {1'b1, 8'h84}) begin n_bad++;
      $display("FAIL ack_hold: valid=%b data=%h want 1/84", ack_valid, ack_data); end
    ack_ready = 1'b1;
    step();
    n_cmp++; if (ack_valid !== 1'b0) begin n_bad++; $display("FAIL ack_release: got %b want 0", ack_valid); end
`endif
  endtask

  task automatic test_payload_sync();
    send_pkt(8'hAA, 8'h01, 8'hAA, 8'hAA, 8'h01);
    step();
    n_cmp++; if ({stream_en, pkt_count} !== {1'b1, 16'd6}) begin n_bad++;
      $display("FAIL payload_sync: stream_en=%b pkt_count=%0d want 1/6", stream_en, pkt_count); end
  endtask

  task automatic test_bad_opc();
    send_pkt(8'hAA, 8'h07, 8'h00, 8'h00, 8'h07);
    step();
    n_cmp++; if ({cmd_err, stream_en, pkt_count} !== {1'b1, 1'b1, 16'd6}) begin n_bad++;
      $display("FAIL bad_opc: cmd_err=%b stream_en=%b pkt_count=%0d want 1/1/6", cmd_err, stream_en, pkt_count); end
  endtask

  task automatic test_reset_in_sccb();
    send_pkt(8'hAA, 8'h03, 8'h05, 8'h06, 8'h00);
    repeat (3) step();
    n_cmp++; if (bus.sccb_req !== 1'b1) begin n_bad++; $display("FAIL rst_sccb_pre: req got %b want 1", bus.sccb_req); end
    reset = 1'b1;
    step();
    n_cmp++; if ({bus.sccb_req, stream_en, pkt_count} !== {1'b0, 1'b0, 16'd0}) begin n_bad++;
      $display("FAIL rst_sccb_drop: req=%b stream_en=%b pkt_count=%0d want 0/0/0", bus.sccb_req, stream_en, pkt_count); end
    reset = 1'b0;
    step();
    bus.sccb_ack = 1'b1;
    step();
    bus.sccb_ack = 1'b0;
    send_pkt(8'hAA, 8'h01, 8'h00, 8'h00, 8'h01);
    step();
    n_cmp++; if ({bus.sccb_req, stream_en, pkt_count} !== {1'b0, 1'b1, 16'd1}) begin n_bad++;
      $display("FAIL stray_ack: req=%b stream_en=%b pkt_count=%0d want 0/1/1", bus.sccb_req, stream_en, pkt_count); end
  endtask

  initial begin
    bus.host_data = 8'h00;
    bus.has_data  = 1'b0;
    bus.sccb_ack  = 1'b0;
    test_reset();
    test_start();
    test_sccb();
    test_bad_chk();
    test_resync();
    test_timeout();
    test_soft_rst();
    test_payload_sync();
    test_bad_opc();
    test_reset_in_sccb();
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
